i2c_cfg_slave: RTL
==================

I2C_CFG_SLAVE -- requirements
Module: i2c_cfg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b111_0100, the 7-bit target address it responds to.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the byte width and register-file address and data width.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port arst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port scl_i, input, 1, the raw I2C SCL line.
REQ-006 SHALL have port sda_i, input, 1, the raw I2C SDA line.
REQ-007 SHALL have port sda_oe, output, 1; when high, the block drives SDA low (open-drain).
REQ-008 SHALL have port wr_valid, output, 1, a one-cycle strobe for a received register write.
REQ-009 SHALL have port wr_addr, output, DATA_WIDTH, the register index of the write.
REQ-010 SHALL have port wr_data, output, DATA_WIDTH, the register value of the write.
REQ-011 SHALL have port busy, output, 1; high from START until STOP.

Function
REQ-012 SHALL pass scl_i and sda_i through 2-flop synchronizers, then a 1-cycle history register for edge detection.
REQ-013 SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as a synchronized SDA rise while SCL is high.
REQ-014 SHALL sample SDA on a synchronized SCL rising edge, and change sda_oe only on the cycle after a synchronized SCL falling edge.
REQ-015 SHALL use the FSM states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA and RDATA_ACK.
REQ-016 SHALL, on START in any state (including a repeated START), go to ADDR and clear its bit counter.
REQ-017 SHALL, on STOP in any state, go to IDLE and release sda_oe within 1 cycle.
REQ-018 SHALL, in ADDR, shift in 8 bits MSB-first; if bits[7:1] equal SLAVE_ADDR, it goes to ADDR_ACK and drives ACK, otherwise it goes to IDLE with no ACK.
REQ-019 SHALL hold ACK (sda_oe=1) from the SCL fall after bit 8 until the following SCL fall.
REQ-020 SHALL, after an ACKed address with R/W=0, go to REG: the first byte loads the register pointer and is ACKed in REG_ACK.
REQ-021 SHALL treat subsequent bytes in WDATA as data: each is ACKed, and wr_valid pulses for exactly 1 cycle, 1 cycle after the 8th bit is sampled, with wr_addr set to the pointer and wr_data set to the byte.
REQ-022 SHALL increment the pointer after each write, wrapping 0xFF to 0x00.
REQ-023 SHALL keep an internal 2^DATA_WIDTH x DATA_WIDTH register file, written on every wr_valid.
REQ-024 SHALL hold wr_addr and wr_data stable between strobes.
REQ-025 SHALL NOT generate wr_valid for a byte interrupted by START or STOP before its 8th bit.

Reset
REQ-026 SHALL, while arst_n=0, asynchronously force the FSM to IDLE and set sda_oe=0, wr_valid=0, busy=0, wr_addr=0, wr_data=0, the pointer to 0 and the synchronizers to 1.
REQ-027 SHALL, when reset asserts mid-transfer, abort the transfer; after release, the block ignores bus activity until the next START.
REQ-028 SHALL NOT clear the register-file contents on reset.

Configuration
REQ-029 SHALL, when macro I2C_SLAVE_READ_EN is defined, ACK an address with R/W=1 and enter RDATA, driving register-file[pointer] MSB-first (sda_oe = ~bit).
REQ-030 SHALL, in RDATA_ACK (read enabled), increment the pointer and continue on a master ACK, and go to IDLE on a master NACK.
REQ-031 SHALL, when I2C_SLAVE_READ_EN is undefined, NACK any R/W=1 address and go to IDLE, with no read datapath present.

Verification
REQ-032 SHALL cover: START, 0xE8, 0x01, 0x05, STOP -> ACK on all 3 bytes, one wr_valid with wr_addr=0x01 and wr_data=0x05, busy falling after STOP.
REQ-033 SHALL cover: START, 0xEA (address 0x75) -> no ACK, FSM in IDLE, zero wr_valid.
REQ-034 SHALL cover: START, 0xE8, 0xFE, 0x11, 0x22, 0x33, STOP -> writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33), showing pointer wrap.
REQ-035 SHALL cover, with I2C_SLAVE_READ_EN: write pointer 0x10 (value 0xA5), repeated START, 0xE9, read 1 byte, master NACK -> 0xA5 returned on SDA; without the macro, 0xE9 is NACKed.
REQ-036 SHALL cover: arst_n low for 3 cycles after 4 data bits -> sda_oe=0, no wr_valid; a following full write completes normally.
REQ-037 SHALL cover: STOP after 5 bits of a data byte -> no wr_valid, FSM in IDLE, sda_oe=0.

Source files
------------

// File: rtl/i2c_cfg_slave.sv
// I2C register-write target: raw SCL/SDA in, one write strobe per data byte, local register file (read-back under I2C_SLAVE_READ_EN).
// Latency: 2-flop sync + 1 history cycle on the bus; wr_valid one cycle after the 8th data bit is sampled.
// Backpressure: none; the bus master paces every transfer and the target only ACKs/NACKs.
module i2c_cfg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b111_0100,
    parameter int         DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  wr_valid,
    output logic [DATA_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);
    localparam int            CW   = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t                state, state_nxt;
    logic                  oe_nxt;
    logic                  scl_s1, scl_s, scl_d, sda_s1, sda_s, sda_d;
    logic                  scl_rise, scl_fall, start, stop;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-2:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] ptr;
    logic                  last_bit, addr_hit, rx_phase, ack_phase;
    logic [DATA_WIDTH-1:0] regs [2**DATA_WIDTH];
`ifdef I2C_SLAVE_READ_EN
    logic                  rw_q;
    logic [DATA_WIDTH-2:0] tx_sh;
`endif

    // Idle-high reset values keep a released bus from looking like an edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            scl_s1 <= 1'b1;
            scl_s  <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s  <= scl_s1;
            scl_d  <= scl_s;
            sda_s1 <= sda_i;
            sda_s  <= sda_s1;
            sda_d  <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start     = scl_s & scl_d & sda_d & ~sda_s;
    assign stop      = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_next   = {rx_sh, sda_s};
    assign last_bit  = scl_rise && (cnt == LAST);
    assign rx_phase  = (state == ADDR) || (state == REG) || (state == WDATA) || (state == RDATA);
    assign ack_phase = (state == ADDR_ACK) || (state == REG_ACK) || (state == WDATA_ACK) || (state == RDATA_ACK);
`ifdef I2C_SLAVE_READ_EN
    assign addr_hit  = (rx_next[DATA_WIDTH-1 -: 7] == SLAVE_ADDR);
`else
    assign addr_hit  = (rx_next[DATA_WIDTH-1 -: 7] == SLAVE_ADDR) && !rx_next[0];
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
        end else begin
            state  <= state_nxt;
            sda_oe <= oe_nxt;
        end
    end

    // sda_oe only moves on SCL falls (or START/STOP), so it lands the cycle after the edge.
    always_comb begin
        state_nxt = state;
        oe_nxt    = sda_oe;
        if (start) begin
            state_nxt = ADDR;
            oe_nxt    = 1'b0;
        end else if (stop) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (last_bit && !addr_hit) begin
                        state_nxt = IDLE;
                    end else if (scl_fall && cnt == FULL) begin
                        state_nxt = ADDR_ACK;
                        oe_nxt    = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
`ifdef I2C_SLAVE_READ_EN
                        if (rw_q) begin
                            state_nxt = RDATA;
                            oe_nxt    = ~regs[ptr][DATA_WIDTH-1];
                        end else begin
                            state_nxt = REG;
                            oe_nxt    = 1'b0;
                        end
`else
                        state_nxt = REG;
                        oe_nxt    = 1'b0;
`endif
                    end
                end
                REG: begin
                    if (scl_fall && cnt == FULL) begin
                        state_nxt = REG_ACK;
                        oe_nxt    = 1'b1;
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_nxt = WDATA;
                        oe_nxt    = 1'b0;
                    end
                end
                WDATA: begin
                    if (scl_fall && cnt == FULL) begin
                        state_nxt = WDATA_ACK;
                        oe_nxt    = 1'b1;
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt == FULL) begin
                            state_nxt = RDATA_ACK;
                            oe_nxt    = 1'b0;
                        end else begin
                            oe_nxt    = ~tx_sh[DATA_WIDTH-2];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_nxt = IDLE;
                    end else if (scl_fall) begin
                        state_nxt = RDATA;
                        oe_nxt    = ~regs[ptr][DATA_WIDTH-1];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt      <= '0;
            rx_sh    <= '0;
            ptr      <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            if (start) begin
                busy <= 1'b1;
            end else if (stop) begin
                busy <= 1'b0;
            end
            if (start || stop) begin
                cnt <= '0;
            end else begin
                if (scl_rise && rx_phase) begin
                    rx_sh <= rx_next[DATA_WIDTH-2:0];
                    cnt   <= cnt + 1'b1;
                end
                if (scl_fall && ack_phase) begin
                    cnt <= '0;
                end
                if (last_bit && state == REG) begin
                    ptr <= rx_next;
                end
                if (last_bit && state == WDATA) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= ptr;
                    wr_data  <= rx_next;
                    ptr      <= ptr + 1'b1;
                end
`ifdef I2C_SLAVE_READ_EN
                // Master ACK on a read byte advances to the next register.
                if (scl_rise && state == RDATA_ACK && !sda_s) begin
                    ptr <= ptr + 1'b1;
                end
`endif
            end
        end
    end

`ifdef I2C_SLAVE_READ_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rw_q  <= 1'b0;
            tx_sh <= '0;
        end else begin
            if (last_bit && state == ADDR) begin
                rw_q <= rx_next[0];
            end
            if (scl_fall && !start && !stop && state_nxt == RDATA && state != RDATA) begin
                tx_sh <= regs[ptr][DATA_WIDTH-2:0];
            end else if (scl_fall && state == RDATA) begin
                tx_sh <= {tx_sh[DATA_WIDTH-3:0], 1'b0};
            end
        end
    end
`endif

    // Register file contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_valid) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule
